// File: rtl/debounce_scheduler_pkg.sv
// Shared types and constants for the time-shared button debouncer.
package debounce_pkg;

  // Scheduler states: idle scan for a changed button, or qualifying one.
  typedef enum logic {
    SCAN = 1'b0,
    QUAL = 1'b1
  } state_t;

  // Depth of the metastability synchronizer on each raw button input.
  localparam int SYNC_STAGES = 2;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// Round-robin first-set-bit finder: scans req starting at ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Candidate position for each offset from ptr, reduced modulo N.
  logic [IW-1:0] pos [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pos
    logic [IW:0] sum;
    logic [IW:0] wrapped;
    assign sum     = {1'b0, ptr} + (IW+1)'(gi);
    assign wrapped = (sum >= (IW+1)'(N)) ? (sum - (IW+1)'(N)) : sum;
    assign pos[gi] = wrapped[IW-1:0];
  end

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[pos[i]]) begin
        valid = 1'b1;
        idx   = pos[i];
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Shares one debounce counter across N_BTN synchronized push buttons,
// qualifying one changed button at a time in round-robin order.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_BTN   = 4,
  parameter int CNT_MAX = 10,
  parameter int CNT_W   = 4,
  localparam int IW     = idx_w(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             busy,
  output logic [IW-1:0]    active_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_BTN - 1);

  logic [N_BTN-1:0] sync_reg [SYNC_STAGES];
  logic [N_BTN-1:0] sync_raw;

  state_t           state_reg,   state_next;
  logic [IW-1:0]    idx_reg,     idx_next;
  logic             target_reg,  target_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [IW-1:0]    ptr_reg,     ptr_next;
  logic [N_BTN-1:0] level_reg,   level_next;
  logic [N_BTN-1:0] press_reg,   press_next;
  logic [N_BTN-1:0] release_reg, release_next;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    ptr_after;
  logic [N_BTN-1:0] diff;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    // Synchronizer stage gi: first stage samples the raw pins.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_reg[gi] <= '0;
      end else if (gi == 0) begin
        sync_reg[gi] <= btn_raw;
      end else begin
        sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  end

  assign sync_raw = sync_reg[SYNC_STAGES-1];
  assign diff     = sync_raw ^ level_reg;

  // Round-robin restarts just after whichever button was last served.
  assign ptr_after = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

  rr_pick #(
    .N  (N_BTN),
    .IW (IW)
  ) u_pick (
    .req   (diff),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Scheduler state, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= SCAN;
      idx_reg     <= '0;
      target_reg  <= 1'b0;
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      level_reg   <= '0;
      press_reg   <= '0;
      release_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      target_reg  <= target_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Next-state: pick a changed button, then count stable cycles or abort.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    target_next  = target_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    level_next   = level_reg;
    press_next   = '0;
    release_next = '0;
    unique case (state_reg)
      SCAN: begin
        if (pick_valid) begin
          idx_next    = pick_idx;
          target_next = sync_raw[pick_idx];
          cnt_next    = '0;
          state_next  = QUAL;
        end
      end
      QUAL: begin
        if (sync_raw[idx_reg] != target_reg) begin
          // Input bounced: drop this attempt and let others have a turn.
          cnt_next   = '0;
          ptr_next   = ptr_after;
          state_next = SCAN;
        end else if (cnt_reg == CNT_LAST) begin
          level_next[idx_reg] = target_reg;
          if (target_reg) begin
            press_next[idx_reg] = 1'b1;
          end else begin
            release_next[idx_reg] = 1'b1;
          end
          ptr_next   = ptr_after;
          state_next = SCAN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign btn_level   = level_reg;
  assign btn_press   = press_reg;
  assign btn_release = release_reg;
  assign busy        = (state_reg == QUAL);
  assign active_idx  = idx_reg;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with default parameters.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       busy;
  logic [1:0] active_idx;

  int tests = 0;
  int fails = 0;

  debounce_scheduler #(
    .N_BTN   (4),
    .CNT_MAX (10),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .busy        (busy),
    .active_idx  (active_idx)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; sample/drive 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " level"},   32'(btn_level),   32'h0);
    chk({tag, " press"},   32'(btn_press),   32'h0);
    chk({tag, " release"}, 32'(btn_release), 32'h0);
    chk({tag, " busy"},    32'(busy),        32'h0);
    chk({tag, " idx"},     32'(active_idx),  32'h0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;

    // Idle: 50 cycles with no input, everything stays 0
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle outs", 32'({btn_level, btn_press, btn_release, busy}), 32'h0);
    end

    // Button 1 press: commits on edge 12 (13th edge), pulse one cycle
    btn_raw = 4'b0010;
    tick(12);
    chk("b1 level before", 32'(btn_level), 32'h0);
    tick(1);
    chk("b1 level", 32'(btn_level), 32'h2);
    chk("b1 press", 32'(btn_press), 32'h2);
    chk("b1 idx",   32'(active_idx), 32'h1);
    tick(1);
    chk("b1 press width", 32'(btn_press), 32'h0);

    // Button 1 release: 13 edges later
    btn_raw = 4'b0000;
    tick(12);
    chk("b1 rel before", 32'(btn_release), 32'h0);
    tick(1);
    chk("b1 release", 32'(btn_release), 32'h2);
    chk("b1 level low", 32'(btn_level), 32'h0);
    tick(1);
    chk("b1 rel width", 32'(btn_release), 32'h0);

    // Button 2 with a 1-cycle glitch seen while cnt=5: abort at edge 8,
    // re-enter QUAL at edge 9, commit at edge 19 (ptr=2 -> pick 2, then ptr=3)
    btn_raw = 4'b0100;
    tick(6);
    btn_raw = 4'b0000;
    tick(1);
    btn_raw = 4'b0100;
    tick(1);
    chk("b2 busy e7", 32'(busy), 32'h1);
    tick(1);
    chk("b2 abort busy", 32'(busy), 32'h0);
    chk("b2 abort nopulse", 32'({btn_press, btn_release}), 32'h0);
    chk("b2 abort level", 32'(btn_level), 32'h0);
    tick(1);
    chk("b2 requal busy", 32'(busy), 32'h1);
    chk("b2 requal idx", 32'(active_idx), 32'h2);
    tick(9);
    chk("b2 level before", 32'(btn_level), 32'h0);
    tick(1);
    chk("b2 level", 32'(btn_level), 32'h4);
    chk("b2 press", 32'(btn_press), 32'h4);
    tick(1);
    chk("b2 press width", 32'(btn_press), 32'h0);

    // Reset with nothing held to restore ptr=0
    btn_raw = 4'b0000;
    reset = 1'b0;
    #1;
    chk_all_zero("reset2");
    tick(2);
    reset = 1'b1;
    tick(2);

    // Buttons 0 and 3 together: 0 at edge 12, 3 at edge 23
    btn_raw = 4'b1001;
    tick(12);
    chk("b03 level e11", 32'(btn_level), 32'h0);
    tick(1);
    chk("b03 level e12", 32'(btn_level), 32'h1);
    chk("b03 press e12", 32'(btn_press), 32'h1);
    chk("b03 idx e12", 32'(active_idx), 32'h0);
    tick(1);
    chk("b03 idx e13", 32'(active_idx), 32'h3);
    chk("b03 busy e13", 32'(busy), 32'h1);
    chk("b03 press e13", 32'(btn_press), 32'h0);
    tick(9);
    chk("b03 level e22", 32'(btn_level), 32'h1);
    tick(1);
    chk("b03 level e23", 32'(btn_level), 32'h9);
    chk("b03 press e23", 32'(btn_press), 32'h8);

    // Release both (ptr=0): 0 at edge 12, 3 at edge 23
    btn_raw = 4'b0000;
    tick(13);
    chk("rel0", 32'(btn_release), 32'h1);
    tick(11);
    chk("rel3", 32'(btn_release), 32'h8);
    chk("rel level", 32'(btn_level), 32'h0);

    // Serve button 1 so ptr becomes 2
    btn_raw = 4'b0010;
    tick(13);
    chk("b1 again press", 32'(btn_press), 32'h2);
    tick(2);

    // Press 0 and 2 together with ptr=2: 2 first, then 0 by wrap
    btn_raw = 4'b0111;
    tick(13);
    chk("wrap first press", 32'(btn_press), 32'h4);
    chk("wrap first idx", 32'(active_idx), 32'h2);
    tick(11);
    chk("wrap second press", 32'(btn_press), 32'h1);
    chk("wrap second idx", 32'(active_idx), 32'h0);
    chk("wrap level", 32'(btn_level), 32'h7);

    // Reset during qualification with button 0 held
    btn_raw = 4'b0001;
    tick(5);
    chk("pre-reset busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    chk_all_zero("midqual reset");
    tick(3);
    reset = 1'b1;
    tick(12);
    chk("post-reset press e11", 32'(btn_press), 32'h0);
    tick(1);
    chk("post-reset press e12", 32'(btn_press), 32'h1);
    chk("post-reset level", 32'(btn_level), 32'h1);
    tick(1);
    chk("post-reset width", 32'(btn_press), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Time-shares a single debounce counter across `N_BTN` raw push-button inputs, replacing one debouncer per button in the clock-division board top. It synchronizes every input, qualifies one changed button at a time for `CNT_MAX` consecutive stable cycles, and serves changed buttons in round-robin order. The debounced levels and single-cycle press/release pulses drive the divider-ratio select and run/stop logic.

## Interface
- `N_BTN`, default 4: number of buttons; must be ≥ 2.
- `CNT_MAX`, default 10: stable cycles required to accept a change; must be ≥ 1.
- `CNT_W`, default 4: counter width; 2^`CNT_W` ≥ `CNT_MAX`.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `btn_raw`  in  `N_BTN`  raw asynchronous button levels, 1 = pressed.
- `btn_level`  out  `N_BTN`  debounced level per button.
- `btn_press`  out  `N_BTN`  one-cycle pulse when a button's level commits 0→1.
- `btn_release`  out  `N_BTN`  one-cycle pulse when a button's level commits 1→0.
- `busy`  out  1  high while a qualification is in progress.
- `active_idx`  out  clog2(`N_BTN`)  index of the button being qualified, or the last one qualified.

## Operation
- Each `btn_raw` bit passes through a 2-flop synchronizer to form `sync_raw`.
- `diff = sync_raw ^ btn_level`.
- Registered pointer `ptr` selects the round-robin start position.
- FSM, two states:
  - SCAN:
    - `busy` = 0.
    - If `diff` ≠ 0, pick the first set bit at or after `ptr`, wrapping around.
    - Latch `idx` and `target = sync_raw[idx]`, clear `cnt`, and go to QUAL.
    - Otherwise stay in SCAN.
  - QUAL:
    - `busy` = 1.
    - Abort: if `sync_raw[idx]` ≠ `target`, clear `cnt`, set `ptr = (idx+1) mod N_BTN`, and go to SCAN. No output change.
    - Commit: else if `cnt` == `CNT_MAX`-1:
      - `btn_level[idx] <= target`.
      - Pulse `btn_press[idx]` if `target` = 1, otherwise pulse `btn_release[idx]`.
      - Set `ptr = (idx+1) mod N_BTN` and go to SCAN.
    - Otherwise `cnt <= cnt+1`.
- Only one button is qualified at a time. Other buttons' changes wait in `diff`, and nothing is lost while they wait.
- A button that bounces back to its committed level before being picked is never served, because its `diff` bit clears.
- Pulse outputs are registered, at most one bit is set per cycle, and each pulse lasts exactly one cycle.
- `active_idx` = `idx`.

## Timing
- Reset values:
  - `btn_level`, `btn_press`, `btn_release`, `busy`, `active_idx` = 0.
  - Synchronizer flops = 0, `ptr` = 0, `cnt` = 0, state = SCAN.
- Reset mid-QUAL discards the qualification. Buttons held pressed through reset re-qualify from SCAN once reset is released.
- Latency for an uncontended, bounce-free change:
  - Let edge 0 be the first rising edge at which the synchronizer samples the new raw value.
  - `btn_level` and the pulse update on edge `CNT_MAX`+2, i.e. on the (`CNT_MAX`+3)th edge.
  - With the defaults this is the 13th edge.
- Minimum spacing between two commits is `CNT_MAX`+1 cycles, because one SCAN cycle sits between qualifications.
- Simultaneous changes on several buttons are served in ptr-relative index order. The k-th served button sees latency increased by (k-1)·(`CNT_MAX`+1).
- `cnt` wraps back to 0 only through the SCAN transition and never overflows `CNT_W`.

## Structure
- Package `debounce_pkg` holds:
  - the state enum {SCAN, QUAL};
  - the `SYNC_STAGES` = 2 constant;
  - the index-width helper (clog2, min 1).
- Sub-module `rr_pick`: combinational first-set-bit finder over an `N_BTN` vector starting at `ptr`, with wrap. Outputs are `valid` and `idx`.
- Synchronizer, FSM, counter and output registers live in the top module.

## Test plan
- Reset, then hold `btn_raw` = 0 for 50 cycles → all outputs remain 0 and `busy` = 0.
- Set `btn_raw[1]` 0→1 and hold → `btn_level[1]` = 1 on the 13th edge, with a `btn_press[1]` pulse exactly 1 cycle wide. Then release → `btn_release[1]` pulse 13 edges later.
- Press `btn_raw[2]`, then toggle it low for 1 cycle at `cnt` = 5 → abort with no pulse. Qualification then restarts and commits 10 QUAL cycles after it re-enters QUAL.
- Press buttons 0 and 3 on the same edge with `ptr` = 0 → button 0 commits at edge 12, button 3 at edge 23. `active_idx` follows 0 then 3.
- With `ptr` = 2 after serving button 1, press buttons 0 and 2 together → button 2 is served first, then button 0 (wrap).
- Assert reset while `busy` = 1 with `btn_raw[0]` held high → outputs clear immediately. After release, `btn_press[0]` pulses on the 13th edge.
